// File: rtl/decode_unit.sv
// Instruction decoder for the 16-bit SIMPLE-style CPU.
// Turns the fetched instruction word into registered datapath controls
// (ALU op, operand selects, immediate extension, write-back, memory, branch).
// Register read addresses are taken straight from the instruction by the
// register file, so only the write address is produced here.
module decode_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] command,
    output logic        se,
    output logic        ar,
    output logic        br,
    output logic [3:0]  s_alu,
    output logic        in,
    output logic        we,
    output logic [2:0]  wAdr,
    output logic        adr,
    output logic        w,
    output logic        pcl,
    output logic [2:0]  cond
);

    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [2:0] OP2_LI    = 3'b000;
    localparam logic [2:0] OP2_B     = 3'b100;
    localparam logic [2:0] OP2_BCOND = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_MOV = 4'b0110;

    localparam logic [2:0] COND_ALWAYS = 3'b100;

    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;

    assign op1 = command[15:14];
    assign op2 = command[13:11];
    assign op3 = command[7:4];

    // Stage 0: combinational decode of the current instruction word
    logic       se_p0;
    logic       ar_p0;
    logic       br_p0;
    logic [3:0] s_alu_p0;
    logic       in_p0;
    logic       we_p0;
    logic [2:0] wadr_p0;
    logic       adr_p0;
    logic       w_p0;
    logic       pcl_p0;
    logic [2:0] cond_p0;

    // Decode the instruction fields into next-cycle control values (NOP by default)
    always_comb begin
        se_p0    = 1'b0;
        ar_p0    = 1'b0;
        br_p0    = 1'b0;
        s_alu_p0 = ALU_ADD;
        in_p0    = 1'b0;
        we_p0    = 1'b0;
        wadr_p0  = 3'b000;
        adr_p0   = 1'b0;
        w_p0     = 1'b0;
        pcl_p0   = 1'b0;
        cond_p0  = 3'b000;
        case (op1)
            OP1_ALU: begin
                case (op3)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110: begin
                        s_alu_p0 = op3;
                        ar_p0    = 1'b1;
                        br_p0    = 1'b1;
                        we_p0    = 1'b1;
                        wadr_p0  = command[10:8];
                    end
                    4'b0101: begin
                        // CMP only updates flags, no register write-back
                        s_alu_p0 = op3;
                        ar_p0    = 1'b1;
                        br_p0    = 1'b1;
                    end
                    4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                        // Shift amount comes from the zero-extended command[3:0]
                        s_alu_p0 = op3;
                        ar_p0    = 1'b1;
                        we_p0    = 1'b1;
                        wadr_p0  = command[10:8];
                    end
                    4'b1100: begin
                        in_p0   = 1'b1;
                        we_p0   = 1'b1;
                        wadr_p0 = command[10:8];
                    end
                    4'b1101: begin
                        // OUT drives register B through the ALU as a pass-through
                        s_alu_p0 = ALU_MOV;
                        br_p0    = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP1_LD: begin
                ar_p0   = 1'b1;
                se_p0   = 1'b1;
                adr_p0  = 1'b1;
                we_p0   = 1'b1;
                wadr_p0 = command[13:11];
            end
            OP1_ST: begin
                ar_p0  = 1'b1;
                se_p0  = 1'b1;
                adr_p0 = 1'b1;
                w_p0   = 1'b1;
            end
            default: begin
                case (op2)
                    OP2_LI: begin
                        s_alu_p0 = ALU_MOV;
                        se_p0    = 1'b1;
                        we_p0    = 1'b1;
                        wadr_p0  = command[10:8];
                    end
                    OP2_B: begin
                        se_p0   = 1'b1;
                        pcl_p0  = 1'b1;
                        cond_p0 = COND_ALWAYS;
                    end
                    OP2_BCOND: begin
                        // Condition codes 1xx are undefined for Bcond and decode as NOP
                        if (!command[10]) begin
                            se_p0   = 1'b1;
                            pcl_p0  = 1'b1;
                            cond_p0 = command[10:8];
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // Stage 1: register the decoded controls; async reset clears them to NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            se    <= 1'b0;
            ar    <= 1'b0;
            br    <= 1'b0;
            s_alu <= 4'b0000;
            in    <= 1'b0;
            we    <= 1'b0;
            wAdr  <= 3'b000;
            adr   <= 1'b0;
            w     <= 1'b0;
            pcl   <= 1'b0;
            cond  <= 3'b000;
        end else begin
            se    <= se_p0;
            ar    <= ar_p0;
            br    <= br_p0;
            s_alu <= s_alu_p0;
            in    <= in_p0;
            we    <= we_p0;
            wAdr  <= wadr_p0;
            adr   <= adr_p0;
            w     <= w_p0;
            pcl   <= pcl_p0;
            cond  <= cond_p0;
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// Directed testbench for decode_unit: table of instruction vectors with
// hand-computed control outputs, plus reset and back-to-back sequences.
module tb_decode_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] command;
    logic        se, ar, br, in_o, we, adr, w, pcl;
    logic [3:0]  s_alu;
    logic [2:0]  wadr, cond;

    int tests;
    int fails;

    decode_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .command(command),
        .se     (se),
        .ar     (ar),
        .br     (br),
        .s_alu  (s_alu),
        .in     (in_o),
        .we     (we),
        .wAdr   (wadr),
        .adr    (adr),
        .w      (w),
        .pcl    (pcl),
        .cond   (cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {se, ar, br, s_alu[3:0], in, we, wAdr[2:0], adr, w, pcl, cond[2:0]}
    function automatic logic [17:0] mk(input logic se_e, input logic ar_e, input logic br_e,
                                       input logic [3:0] alu_e, input logic in_e, input logic we_e,
                                       input logic [2:0] wa_e, input logic adr_e, input logic w_e,
                                       input logic pcl_e, input logic [2:0] cond_e);
        return {se_e, ar_e, br_e, alu_e, in_e, we_e, wa_e, adr_e, w_e, pcl_e, cond_e};
    endfunction

    function automatic logic [17:0] outs();
        return {se, ar, br, s_alu, in_o, we, wadr, adr, w, pcl, cond};
    endfunction

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (se,ar,br,alu,in,we,wAdr,adr,w,pcl,cond)",
                     name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] cmd;
        logic [17:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];
    logic [17:0] zero;
    logic [17:0] exp_add;
    logic [17:0] exp_ld;

    initial begin
        tests = 0;
        fails = 0;
        zero  = '0;
        //                                          se  ar  br  alu      in  we  wAdr    adr w   pcl cond
        exp_add = mk(0, 1, 1, 4'b0000, 0, 1, 3'b101, 0, 0, 0, 3'b000);
        exp_ld  = mk(1, 1, 0, 4'b0000, 0, 1, 3'b111, 1, 0, 0, 3'b000);
        vecs[0]  = '{"ADD",   16'b11_111_101_0000_1111, exp_add};
        vecs[1]  = '{"AND",   16'b11_111_101_0010_0000, mk(0,1,1,4'b0010,0,1,3'b101,0,0,0,3'b000)};
        vecs[2]  = '{"CMP",   16'b11_111_101_0101_0000, mk(0,1,1,4'b0101,0,0,3'b000,0,0,0,3'b000)};
        vecs[3]  = '{"SUB",   16'b11_000_011_0001_0000, mk(0,1,1,4'b0001,0,1,3'b011,0,0,0,3'b000)};
        vecs[4]  = '{"OR",    16'b11_010_110_0011_1010, mk(0,1,1,4'b0011,0,1,3'b110,0,0,0,3'b000)};
        vecs[5]  = '{"XOR",   16'b11_000_001_0100_0000, mk(0,1,1,4'b0100,0,1,3'b001,0,0,0,3'b000)};
        vecs[6]  = '{"MOV",   16'b11_000_010_0110_0000, mk(0,1,1,4'b0110,0,1,3'b010,0,0,0,3'b000)};
        vecs[7]  = '{"SLL",   16'b11_000_001_1000_0001, mk(0,1,0,4'b1000,0,1,3'b001,0,0,0,3'b000)};
        vecs[8]  = '{"SRA",   16'b11_000_110_1011_0011, mk(0,1,0,4'b1011,0,1,3'b110,0,0,0,3'b000)};
        vecs[9]  = '{"IN",    16'b11_000_100_1100_0000, mk(0,0,0,4'b0000,1,1,3'b100,0,0,0,3'b000)};
        vecs[10] = '{"OUT",   16'b11_000_100_1101_0000, mk(0,0,1,4'b0110,0,0,3'b000,0,0,0,3'b000)};
        vecs[11] = '{"HLT",   16'b11_111_111_1111_1111, zero};
        vecs[12] = '{"OP3_7", 16'b11_101_011_0111_0101, zero};
        vecs[13] = '{"LD",    16'b00_111_101_00000000,  exp_ld};
        vecs[14] = '{"ST",    16'b01_111_101_00000000,  mk(1,1,0,4'b0000,0,0,3'b000,1,1,0,3'b000)};
        vecs[15] = '{"LI",    16'b10_000_011_01010101,  mk(1,0,0,4'b0110,0,1,3'b011,0,0,0,3'b000)};
        vecs[16] = '{"BLT",   16'b10_111_001_11111110,  mk(1,0,0,4'b0000,0,0,3'b000,0,0,1,3'b001)};
        vecs[17] = '{"B",     16'b10_100_000_00000010,  mk(1,0,0,4'b0000,0,0,3'b000,0,0,1,3'b100)};
        vecs[18] = '{"BC101", 16'b10_111_101_00000000,  zero};
        vecs[19] = '{"OP2_2", 16'b10_010_000_11110000,  zero};

        // Reset asserted from time zero: outputs must be 0 before any clock edge
        rst_n   = 1'b0;
        command = 16'b11_111_101_0000_1111;
        #2;
        check("reset_no_edge", outs(), zero);
        @(posedge clk);
        #1;
        check("reset_held_edge", outs(), zero);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_release", outs(), zero);
        @(posedge clk);
        #1;
        check("first_edge_add", outs(), exp_add);

        // Table-driven: each vector driven at negedge and checked 1ns after the edge
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            command = vecs[i].cmd;
            @(posedge clk);
            #1;
            check(vecs[i].name, outs(), vecs[i].exp);
            tests++;
            if (w && we) begin
                fails++;
                $display("FAIL %s_w_we: w=%b we=%b both set", vecs[i].name, w, we);
            end
        end

        // Back-to-back ADD then LD then ADD: outputs update every cycle
        @(negedge clk);
        command = 16'b11_111_101_0000_1111;
        @(posedge clk);
        #1;
        check("b2b_add", outs(), exp_add);
        command = 16'b00_111_101_00000000;
        @(posedge clk);
        #1;
        check("b2b_ld", outs(), exp_ld);
        command = 16'b11_111_101_0000_1111;
        @(posedge clk);
        #1;
        check("b2b_add2", outs(), exp_add);

        // Mid-stream reset: clears immediately and discards the pending decode
        command = 16'b00_111_101_00000000;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", outs(), zero);
        @(posedge clk);
        #1;
        check("midreset_held", outs(), zero);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset_release", outs(), zero);
        @(posedge clk);
        #1;
        check("midreset_resume_ld", outs(), exp_ld);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
